// File: rtl/lsu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_arb_pkg
// Purpose  : Shared types and constants for the LSU bank arbiter: bank-select
//            width, slot encoding (slot id = 2*lsu + is_write) and the read
//            return tag carried through the per-bank tag pipe.
// Revision : 1.0  initial release
// ============================================================================
package lsu_arb_pkg;

    // Bank select width; supports up to four banks.
    localparam int SEL_W    = 2;
    // LSU id width carried in read tags; supports up to four LSUs.
    localparam int LSU_ID_W = 2;

    // Low bit of a slot id: which kind of access the slot carries.
    typedef enum logic {
        SLOT_READ  = 1'b0,
        SLOT_WRITE = 1'b1
    } slot_kind_e;

    // Read return tag: one outstanding read per bank per pipe stage.
    typedef struct packed {
        logic                valid;
        logic [LSU_ID_W-1:0] lsu_id;
    } tag_t;

    // Slot id for a given LSU and access kind.
    function automatic int slot_id(input int lsu, input slot_kind_e kind);
        return 2 * lsu + ((kind == SLOT_WRITE) ? 1 : 0);
    endfunction

endpackage : lsu_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. The first requesting slot at or
//            after i_ptr (wrapping modulo N) wins.
// Ports    : i_req    [N]      request per slot
//            i_ptr    [IDX_W]  round-robin start slot
//            o_gnt    [N]      one-hot grant
//            o_winner [IDX_W]  index of the granted slot
//            o_valid           at least one slot requested
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_valid
);

    int w_idx;

    always_comb begin
        o_gnt    = '0;
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        // Scan N slots starting at the pointer; the first hit wins.
        for (int i = 0; i < N; i++) begin
            w_idx = (int'(i_ptr) + i) % N;
            if (!o_valid && i_req[w_idx[IDX_W-1:0]]) begin
                o_valid                   = 1'b1;
                o_winner                  = w_idx[IDX_W-1:0];
                o_gnt[w_idx[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/lsu_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bank_arbiter
// Purpose  : Shares NUM_BANK single-port synchronous banks among NUM_LSU
//            load/store units. One grant per bank per cycle (round-robin over
//            2*NUM_LSU slots: slot 2k = LSU k read, 2k+1 = LSU k write),
//            registered bank issue, 2-cycle read return via per-bank tag pipe.
// Ports    : clk, rst (async, active-low), run
//            r_req         per LSU {r_sel, ren}
//            w_req         per LSU {w_sel, wen, wdata}
//            addr_bus      per LSU {addr_sel (reserved), ADDR}
//            lsu_stall     per LSU, combinational: a request lost this cycle
//            lsu_rdata_bus per LSU {read_valid, din}
//            bank_en/we/addr/wdata  registered bank issue
//            bank_rdata    bank read data, valid one cycle after a read issue
//            conflict_cnt  per-bank 32-bit conflict counters
// Config   : ARB_CONFLICT_CNT_EN - build saturating per-bank conflict
//            counters (cycles with more than one requesting slot); otherwise
//            conflict_cnt is tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module lsu_bank_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int NUM_LSU  = 4,
    parameter int NUM_BANK = 4,
    parameter int A_W      = 10,
    parameter int D_W      = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run,
    input  logic [NUM_LSU*(SEL_W+1)-1:0]     r_req,
    input  logic [NUM_LSU*(SEL_W+1+D_W)-1:0] w_req,
    input  logic [NUM_LSU*(SEL_W+A_W)-1:0]   addr_bus,
    output logic [NUM_LSU-1:0]               lsu_stall,
    output logic [NUM_LSU*(1+D_W)-1:0]       lsu_rdata_bus,
    output logic [NUM_BANK-1:0]              bank_en,
    output logic [NUM_BANK-1:0]              bank_we,
    output logic [NUM_BANK*A_W-1:0]          bank_addr,
    output logic [NUM_BANK*D_W-1:0]          bank_wdata,
    input  logic [NUM_BANK*D_W-1:0]          bank_rdata,
    output logic [NUM_BANK*32-1:0]           conflict_cnt
);

    localparam int NSLOT  = 2 * NUM_LSU;
    localparam int SLOT_W = $clog2(NSLOT);
    localparam int RQ_W   = SEL_W + 1;
    localparam int WQ_W   = SEL_W + 1 + D_W;
    localparam int AB_W   = SEL_W + A_W;
    localparam int RD_W   = 1 + D_W;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on the second clock edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rst_sync <= '0;
        else      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [NUM_LSU-1:0] w_rd_req, w_wr_req;
    logic [SEL_W-1:0]   w_rd_sel [NUM_LSU];
    logic [SEL_W-1:0]   w_wr_sel [NUM_LSU];
    logic [A_W-1:0]     w_addr   [NUM_LSU];
    logic [D_W-1:0]     w_wdata  [NUM_LSU];
    logic [NSLOT-1:0]   w_bank_req [NUM_BANK];
    logic [NSLOT-1:0]   w_gnt      [NUM_BANK];
    logic [SLOT_W-1:0]  w_winner   [NUM_BANK];
    logic [NUM_BANK-1:0] w_any;
    logic [NSLOT-1:0]   w_slot_gnt;
    tag_t               w_tag2     [NUM_BANK];
    logic [NUM_LSU*SEL_W-1:0] w_unused_addr_sel;

    always_comb begin
        for (int k = 0; k < NUM_LSU; k++) begin
            w_rd_req[k] = run & r_req[k*RQ_W];
            w_rd_sel[k] = r_req[k*RQ_W+1 +: SEL_W];
            w_wr_req[k] = run & w_req[k*WQ_W+D_W];
            w_wr_sel[k] = w_req[k*WQ_W+D_W+1 +: SEL_W];
            w_wdata[k]  = w_req[k*WQ_W +: D_W];
            w_addr[k]   = addr_bus[k*AB_W +: A_W];
            w_unused_addr_sel[k*SEL_W +: SEL_W] = addr_bus[k*AB_W+A_W +: SEL_W];
        end
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int k = 0; k < NUM_LSU; k++) begin
                w_bank_req[b][2*k]   = w_rd_req[k] && (int'(w_rd_sel[k]) == b);
                w_bank_req[b][2*k+1] = w_wr_req[k] && (int'(w_wr_sel[k]) == b);
            end
        end
    end

    // Each slot targets exactly one bank, so OR-ing grants is unambiguous.
    always_comb begin
        w_slot_gnt = '0;
        for (int b = 0; b < NUM_BANK; b++) w_slot_gnt = w_slot_gnt | w_gnt[b];
        for (int k = 0; k < NUM_LSU; k++) begin
            lsu_stall[k] = (w_rd_req[k] & ~w_slot_gnt[2*k]) |
                           (w_wr_req[k] & ~w_slot_gnt[2*k+1]);
        end
    end

    // ------------------------------------------------------------------
    // Per-bank arbitration, issue registers, tag pipe, conflict counter
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [SLOT_W-1:0]   r_rr_ptr;
        logic                r_en, r_we;
        logic [A_W-1:0]      r_addr;
        logic [D_W-1:0]      r_wdata;
        tag_t                r_tag1, r_tag2;
        logic [LSU_ID_W-1:0] w_lsu;

        rr_arbiter #(.N(NSLOT), .IDX_W(SLOT_W)) u_rr_arbiter (
            .i_req    (w_bank_req[b]),
            .i_ptr    (r_rr_ptr),
            .o_gnt    (w_gnt[b]),
            .o_winner (w_winner[b]),
            .o_valid  (w_any[b])
        );

        assign w_lsu = w_winner[b][SLOT_W-1:1];

        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_rr_ptr <= '0;
                r_en     <= 1'b0;
                r_we     <= 1'b0;
                r_addr   <= '0;
                r_wdata  <= '0;
                r_tag1   <= '0;
                r_tag2   <= '0;
            end else begin
                r_en   <= w_any[b];
                r_we   <= w_any[b] & (w_winner[b][0] == SLOT_WRITE);
                if (w_any[b]) begin
                    r_rr_ptr <= (w_winner[b] == SLOT_W'(NSLOT-1)) ? '0
                                                                  : w_winner[b] + 1'b1;
                    r_addr   <= w_addr[w_lsu];
                    r_wdata  <= w_wdata[w_lsu];
                end
                // Stage 1 aligns with the bank strobe, stage 2 with bank_rdata.
                r_tag1 <= '{valid:  w_any[b] & (w_winner[b][0] == SLOT_READ),
                            lsu_id: w_lsu};
                r_tag2 <= r_tag1;
            end
        end

        assign bank_en[b]                = r_en;
        assign bank_we[b]                = r_we;
        assign bank_addr[b*A_W +: A_W]   = r_addr;
        assign bank_wdata[b*D_W +: D_W]  = r_wdata;
        assign w_tag2[b]                 = r_tag2;

`ifdef ARB_CONFLICT_CNT_EN
        logic [31:0] r_conflict;
        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n)
                r_conflict <= '0;
            else if (($countones(w_bank_req[b]) > 1) && (r_conflict != 32'hffff_ffff))
                r_conflict <= r_conflict + 32'd1;
        end
        assign conflict_cnt[b*32 +: 32] = r_conflict;
`else
        assign conflict_cnt[b*32 +: 32] = '0;
`endif
    end

    // ------------------------------------------------------------------
    // Read return: an LSU has at most one read slot, so at most one bank
    // can carry a valid tag for it in any cycle.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_LSU; k++) begin : g_lsu
        logic           w_rv;
        logic [D_W-1:0] w_rdin;
        logic [D_W-1:0] r_din;

        always_comb begin
            w_rv   = 1'b0;
            w_rdin = r_din;
            for (int b = 0; b < NUM_BANK; b++) begin
                if (w_tag2[b].valid && (w_tag2[b].lsu_id == LSU_ID_W'(k))) begin
                    w_rv   = 1'b1;
                    w_rdin = bank_rdata[b*D_W +: D_W];
                end
            end
        end

        // Holds the last returned data; resets to all-ones like load_reg.
        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n)  r_din <= '1;
            else if (w_rv) r_din <= w_rdin;
        end

        assign lsu_rdata_bus[k*RD_W +: RD_W] = {w_rv, w_rdin};
    end

endmodule : lsu_bank_arbiter
`default_nettype wire
